// File: rtl/fifo_skew_reader_pkg.sv
// Shared types for the diagonal-wavefront row FIFO reader.
// State encoding and step counter width helper.
package fifo_skew_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int MAX_LEN = 64;

    function automatic int STEP_W(input int rows);
        return $clog2(MAX_LEN + rows);
    endfunction

endpackage

// File: rtl/fifo_skew_reader_slot.sv
// One row of the wavefront: active-window compare plus the
// output data/valid register feeding one PE array row.
module skew_row_slot
    import fifo_skew_pkg::*;
#(
    parameter int IDX   = 0,
    parameter int EW    = 4,
    parameter int SW    = 7,
    parameter int LEN_W = 7
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [SW-1:0]    step_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             pop_i,
    input  logic [EW-1:0]    din_i,
    output logic             active_o,
    output logic [EW-1:0]    dout_o,
    output logic             valid_o
);

    localparam int CW = ((SW > LEN_W) ? SW : LEN_W) + 1;

    logic [CW-1:0] step_w;
    logic [CW-1:0] len_w;
    logic [CW-1:0] idx_w;
    logic [EW-1:0] dout_q;
    logic          valid_q;

    assign step_w = CW'(step_i);
    assign len_w  = CW'(len_i);
    assign idx_w  = CW'(IDX);

    // Row IDX owns steps IDX .. IDX+len-1.
    assign active_o = (step_w >= idx_w) && ((step_w - idx_w) < len_w);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= pop_i;
            if (pop_i) begin
                dout_q <= din_i;
            end
        end
    end

    assign dout_o  = dout_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fifo_skew_reader.sv
// Drains row FIFOs in a diagonal wavefront for a systolic array.
// Define FIFO_SKEW_STALL_CNT_EN to add the stall_cnt port and counter.
module fifo_skew_reader
    import fifo_skew_pkg::*;
#(
    parameter int bw    = 4,
    parameter int simd  = 1,
    parameter int row   = 8,
    parameter int len_w = 7
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [len_w-1:0]         len,
    input  logic [row-1:0]           fifo_empty,
    input  logic [row*simd*bw-1:0]   fifo_out,
    output logic [row-1:0]           fifo_rd,
    output logic [row*simd*bw-1:0]   data_out,
    output logic [row-1:0]           data_valid,
    output logic                     busy,
    output logic                     done
`ifdef FIFO_SKEW_STALL_CNT_EN
    ,
    output logic [15:0]              stall_cnt
`endif
);

    localparam int EW = simd * bw;
    localparam int SW = STEP_W(row);

    state_e           state_q;
    logic [SW-1:0]    step_q;
    logic [len_w-1:0] len_q;
    logic             busy_q;
    logic             done_q;

    logic [row-1:0]   active;
    logic [row-1:0]   ok_row;
    logic             ready;
    logic             run;
    logic             pop;
    logic             accept;
    logic             last;
    logic [SW-1:0]    last_step;

    // A row is fine if it is idle this step or has data waiting.
    assign ok_row    = ~active | ~fifo_empty;
    assign ready     = &ok_row;
    assign run       = (state_q == RUN);
    assign pop       = run && ready;
    assign accept    = (state_q == IDLE) && start && (len != '0);
    assign last_step = SW'(len_q) + SW'(row - 2);
    assign last      = (step_q == last_step);
    assign fifo_rd   = pop ? active : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            step_q  <= '0;
            len_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        state_q <= RUN;
                        len_q   <= len;
                        step_q  <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (pop) begin
                        if (last) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            step_q <= step_q + SW'(1);
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    step_q  <= '0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    step_q  <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;

    for (genvar g = 0; g < row; g++) begin : g_slot
        skew_row_slot #(
            .IDX   (g),
            .EW    (EW),
            .SW    (SW),
            .LEN_W (len_w)
        ) u_slot (
            .clk      (clk),
            .reset_n  (reset_n),
            .step_i   (step_q),
            .len_i    (len_q),
            .pop_i    (fifo_rd[g]),
            .din_i    (fifo_out[g*EW +: EW]),
            .active_o (active[g]),
            .dout_o   (data_out[g*EW +: EW]),
            .valid_o  (data_valid[g])
        );
    end

`ifdef FIFO_SKEW_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
        end else if (accept) begin
            stall_q <= '0;
        end else if (run && !ready && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_fifo_skew_reader.sv
// Bench for fifo_skew_reader: queue-based row FIFOs and a
// step-window reference model checked every cycle.
module tb_fifo_skew_reader;

    localparam int ROW = 4;
    localparam int BW  = 4;
    localparam int SIMD = 1;
    localparam int LW  = 7;
    localparam int EW  = BW * SIMD;
    localparam int DW  = ROW * EW;
    localparam int BUDGET = 600;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            start;
    logic [LW-1:0]   len;
    logic [ROW-1:0]  fifo_empty;
    logic [DW-1:0]   fifo_out;
    logic [ROW-1:0]  fifo_rd;
    logic [DW-1:0]   data_out;
    logic [ROW-1:0]  data_valid;
    logic            busy;
    logic            done;
`ifdef FIFO_SKEW_STALL_CNT_EN
    logic [15:0]     stall_cnt;
`endif

    fifo_skew_reader #(
        .bw    (BW),
        .simd  (SIMD),
        .row   (ROW),
        .len_w (LW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .len        (len),
        .fifo_empty (fifo_empty),
        .fifo_out   (fifo_out),
        .fifo_rd    (fifo_rd),
        .data_out   (data_out),
        .data_valid (data_valid),
        .busy       (busy),
        .done       (done)
`ifdef FIFO_SKEW_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [EW-1:0]  fq [ROW][$];
    logic [ROW-1:0] hold;
    logic [ROW-1:0] rd_trace [$];

    int             m_state;
    int             m_step;
    int             m_len;
    int             m_stall;
    logic [ROW-1:0] m_valid;
    logic [DW-1:0]  m_data;

    int vectors = 0;
    int miscompares = 0;
    int done_at;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < ROW; i++) begin
            fifo_empty[i] = (fq[i].size() == 0) || hold[i];
            fifo_out[i*EW +: EW] = (fq[i].size() > 0) ? fq[i][0] : '0;
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_step  = 0;
        m_len   = 0;
        m_stall = 0;
        m_valid = '0;
        m_data  = '0;
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < ROW; i++) begin
            fq[i].delete();
            repeat (n) fq[i].push_back(EW'($urandom_range(0, 15)));
        end
    endtask

    task automatic check_outputs();
        chk("data_valid", data_valid, m_valid);
        chk("data_out", data_out, m_data);
        chk("busy", busy, (m_state == 1));
        chk("done", done, (m_state == 2));
`ifdef FIFO_SKEW_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, m_stall);
`endif
    endtask

    task automatic tick(input bit st, input int ln, input logic [ROW-1:0] hd,
                        output logic [ROW-1:0] rd_seen);
        logic [ROW-1:0] act;
        logic [ROW-1:0] exp_rd;
        bit             rdy;
        start = st;
        len   = LW'(ln);
        hold  = hd;
        drive();
        #2;
        act = '0;
        rdy = 1'b1;
        for (int i = 0; i < ROW; i++) begin
            if (m_state == 1 && m_step >= i && m_step < i + m_len) act[i] = 1'b1;
            if (act[i] && (fq[i].size() == 0 || hd[i])) rdy = 1'b0;
        end
        exp_rd = (m_state == 1 && rdy) ? act : '0;
        chk("fifo_rd", fifo_rd, exp_rd);
        chk("rd_to_empty", fifo_rd & fifo_empty, 0);
        rd_seen = fifo_rd;
        m_valid = exp_rd;
        for (int i = 0; i < ROW; i++)
            if (exp_rd[i]) m_data[i*EW +: EW] = fq[i][0];
        case (m_state)
            0: if (st && ln != 0) begin
                m_state = 1;
                m_len   = ln;
                m_step  = 0;
                m_stall = 0;
            end
            1: if (rdy) begin
                if (m_step == m_len + ROW - 2) m_state = 2;
                else m_step++;
            end else if (m_stall < 65535) begin
                m_stall++;
            end
            default: begin
                m_state = 0;
                m_step  = 0;
            end
        endcase
        @(posedge clk);
        #1;
        for (int i = 0; i < ROW; i++)
            if (rd_seen[i] && fq[i].size() > 0) void'(fq[i].pop_front());
        start = 1'b0;
        hold  = '0;
        drive();
        check_outputs();
    endtask

    task automatic run_xfer(input int l, input int hrow, input int hstep,
                            input int hcyc, input bit rnd,
                            input int busy_start_at, input int rst_step);
        logic [ROW-1:0] rd;
        logic [ROW-1:0] hd;
        int  n;
        int  held;
        bit  st;
        int  ln;
        bit  was_reset;
        fill(l);
        rd_trace.delete();
        done_at   = 0;
        held      = 0;
        was_reset = 1'b0;
        tick(1'b1, l, '0, rd);
        n = 1;
        while (m_state != 0 && n < BUDGET) begin
            if (rst_step >= 0 && m_state == 1 && m_step == rst_step) begin
                reset_n = 1'b0;
                #1;
                chk("rst_fifo_rd", fifo_rd, 0);
                chk("rst_valid", data_valid, 0);
                chk("rst_data", data_out, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                model_reset();
                @(posedge clk);
                #1;
                reset_n   = 1'b1;
                was_reset = 1'b1;
                break;
            end
            hd = '0;
            if (m_state == 1 && m_step == hstep && held < hcyc) begin
                hd[hrow] = 1'b1;
                held++;
            end
            if (rnd && $urandom_range(0, 3) == 0) hd |= ROW'($urandom);
            st = (n == busy_start_at);
            ln = st ? int'($urandom_range(1, 64)) : 0;
            tick(st, ln, hd, rd);
            n++;
            if (rd != '0) rd_trace.push_back(rd);
            if (done) done_at = n;
        end
        if (n >= BUDGET) begin
            miscompares++;
            $error("FAIL timeout: observed %0d cycles expected < %0d", n, BUDGET);
        end
        if (!was_reset) chk("drained_empty", fifo_empty, {ROW{1'b1}});
    endtask

    logic [ROW-1:0] diag [6];
    logic [ROW-1:0] rd_i;

    initial begin
        diag = '{4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000};
        reset_n = 1'b0;
        start   = 1'b0;
        len     = '0;
        hold    = '0;
        model_reset();
        fill(0);
        drive();
        #12;
        check_outputs();
        chk("reset_fifo_rd", fifo_rd, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        run_xfer(3, 0, -1, 0, 1'b0, -1, -1);
        chk("t1_pops", rd_trace.size(), 6);
        for (int k = 0; k < 6; k++)
            if (k < rd_trace.size()) chk("t1_diag", rd_trace[k], diag[k]);
        chk("t1_done_at", done_at, 7);

        run_xfer(5, 2, 2, 3, 1'b0, -1, -1);
        chk("t2_done_at", done_at, 5 + ROW + 3);
`ifdef FIFO_SKEW_STALL_CNT_EN
        chk("t2_stall_cnt", stall_cnt, 3);
`endif

        run_xfer(64, 0, -1, 0, 1'b0, -1, -1);
        chk("t3_done_at", done_at, 64 + ROW);

        fill(4);
        tick(1'b1, 0, '0, rd_i);
        repeat (3) tick(1'b0, 0, '0, rd_i);
        run_xfer(6, 0, -1, 0, 1'b0, 3, -1);
        chk("t4_done_at", done_at, 6 + ROW);

        run_xfer(10, 0, -1, 0, 1'b0, -1, 5);
        tick(1'b0, 0, '0, rd_i);
        run_xfer(10, 0, -1, 0, 1'b0, -1, -1);
        chk("t5_done_at", done_at, 10 + ROW);

        repeat (6) begin
            run_xfer($urandom_range(1, 64), 0, -1, 0, 1'b1, -1, -1);
            tick(1'b0, 0, ROW'($urandom), rd_i);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
